// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out receiver with a double-buffered valid/ready word output.
// Bits shift in LSB- or MSB-first; the direction is latched on the first bit of each word.
module sipo_deserializer #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_shift,
    input  logic             sin,
    input  logic             right_left,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg, sreg_d, shifted;
    logic [CW-1:0]    cnt_d;
    logic             dir_q, dir_d, shift_dir;
    logic             complete;

    // The first bit of a word uses the live direction input; later bits use the latched one.
    assign shift_dir = (state_q == IDLE) ? right_left : dir_q;
    assign shifted   = shift_dir ? {sin, sreg[WIDTH-1:1]}
                                 : {sreg[WIDTH-2:0], sin};

    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_cnt;
        sreg_d   = sreg;
        dir_d    = dir_q;
        complete = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
        end else if (en_shift) begin
            sreg_d = shifted;
            case (state_q)
                IDLE: begin
                    dir_d   = right_left;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        cnt_d    = '0;
                        state_d  = IDLE;
                        complete = 1'b1;
                    end else begin
                        cnt_d = bit_cnt + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg    <= sreg_d;
            bit_cnt <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // A finished word loads only if the holding register is empty or draining this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (complete && (!data_valid || data_ready)) begin
                data_out   <= sreg_d;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (clear)
                overrun <= 1'b0;
            else if (complete && data_valid && !data_ready)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer (WIDTH = 8): directed table,
// corner-case sequences and a random run against a queue-based reference.
module tb_sipo_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en_shift = 1'b0;
    logic         sin = 1'b0;
    logic         right_left = 1'b0;
    logic         clear = 1'b0;
    logic         data_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         overrun;
    logic [3:0]   bit_cnt;

    int tests = 0;
    int fails = 0;

    bit         mq[$];
    bit         mdir = 1'b0;
    bit         mvalid = 1'b0;
    bit         movr = 1'b0;
    logic [W-1:0] mout = '0;

    typedef struct {
        bit         sin;
        logic [7:0] out;
        bit         valid;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[8];

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en_shift(en_shift), .sin(sin),
        .right_left(right_left), .clear(clear), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready),
        .overrun(overrun), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mvalid = 1'b0;
        movr   = 1'b0;
        mout   = '0;
    endtask

    // Drive one cycle, advance the reference at the edge, then compare.
    task automatic step(bit en, bit s, bit rl, bit clr, bit rdy);
        logic [W-1:0] w;
        bit done;
        w = '0;
        done = 1'b0;
        en_shift = en; sin = s; right_left = rl; clear = clr; data_ready = rdy;
        @(posedge clk);
        if (clr) begin
            mq.delete();
        end else if (en) begin
            if (mq.size() == 0) mdir = rl;
            mq.push_back(s);
            if (mq.size() == W) begin
                for (int i = 0; i < W; i++)
                    if (mdir) w[i] = mq[i];
                    else      w[W-1-i] = mq[i];
                mq.delete();
                done = 1'b1;
            end
        end
        if (clr) movr = 1'b0;
        if (done && mvalid && !rdy) movr = 1'b1;
        else if (done) begin
            mout = w;
            mvalid = 1'b1;
        end else if (mvalid && rdy) mvalid = 1'b0;
        #1;
        chk("model data_out", 32'(data_out), 32'(mout));
        chk("model data_valid", 32'(data_valid), 32'(mvalid));
        chk("model overrun", 32'(overrun), 32'(movr));
        chk("model bit_cnt", 32'(bit_cnt), 32'(mq.size()));
    endtask

    task automatic send_word(logic [W-1:0] w, bit lsb, bit rdy_mid, bit rdy_last);
        for (int i = 0; i < W; i++)
            step(1'b1, lsb ? w[i] : w[W-1-i], lsb, 1'b0,
                 (i == W - 1) ? rdy_last : rdy_mid);
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] v3c;
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tbl[i].sin   = a5[i];
            tbl[i].out   = (i == 7) ? 8'hA5 : 8'h00;
            tbl[i].valid = (i == 7);
            tbl[i].cnt   = (i == 7) ? 4'd0 : 4'(i + 1);
        end

        #12;
        chk("reset data_out", 32'(data_out), 0);
        chk("reset data_valid", 32'(data_valid), 0);
        chk("reset overrun", 32'(overrun), 0);
        chk("reset bit_cnt", 32'(bit_cnt), 0);
        rst_n = 1'b1;

        // LSB-first 8'hA5 from the vector table
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].sin, 1'b1, 1'b0, 1'b0);
            chk("tbl data_out", 32'(data_out), 32'(tbl[i].out));
            chk("tbl data_valid", 32'(data_valid), 32'(tbl[i].valid));
            chk("tbl bit_cnt", 32'(bit_cnt), 32'(tbl[i].cnt));
        end

        // MSB-first 8'h3C with gaps and right_left toggling after bit 2
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        v3c = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, v3c[7-i], (i < 2) ? 1'b0 : 1'(i % 2), 1'b0, 1'b0);
            if (i < 7)
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'(g), 1'(g + i), 1'b0, 1'b0);
                    chk("gap bit_cnt hold", 32'(bit_cnt), 32'(i + 1));
                end
        end
        chk("msb data_out", 32'(data_out), 32'h3C);
        chk("msb data_valid", 32'(data_valid), 1);

        // Back-to-back words, consumer takes each on the completing edge
        send_word(8'h11, 1'b1, 1'b0, 1'b1);
        chk("b2b first", 32'(data_out), 32'h11);
        send_word(8'h22, 1'b0, 1'b0, 1'b1);
        chk("b2b second", 32'(data_out), 32'h22);
        chk("b2b valid", 32'(data_valid), 1);
        chk("b2b overrun", 32'(overrun), 0);

        // Overrun
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h55, 1'b1, 1'b0, 1'b0);
        send_word(8'hAA, 1'b1, 1'b0, 1'b0);
        chk("ovr data_out", 32'(data_out), 32'h55);
        chk("ovr flag", 32'(overrun), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr drained valid", 32'(data_valid), 0);
        chk("ovr sticky", 32'(overrun), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr cleared", 32'(overrun), 0);

        // Clear mid-word with en_shift high
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clear bit_cnt", 32'(bit_cnt), 0);
        send_word(8'hC3, 1'b1, 1'b0, 1'b0);
        chk("clear data_out", 32'(data_out), 32'hC3);

        // Async reset between edges with a pending word and a partial word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset data_out", 32'(data_out), 0);
        chk("areset data_valid", 32'(data_valid), 0);
        chk("areset overrun", 32'(overrun), 0);
        chk("areset bit_cnt", 32'(bit_cnt), 0);
        model_reset();
        #1 rst_n = 1'b1;

        // Random traffic against the reference
        for (int n = 0; n < 3000; n++)
            step(1'($urandom_range(0, 9) < 6), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 9) < 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
